// File: rtl/seqdet_pkg.sv
// -----------------------------------------------------------------------------
// seqdet_pkg
// Shared definitions for the programmable serial-pattern detector family.
//   SEQDET_NOL / SEQDET_OVL : overlap-mode encodings (0 = non-overlapping)
//   SEQDET_DEF_*            : configuration loaded at reset
//   seqdet_cfg_t            : configuration bundle {pattern, len, overlap}
//                             sized for the default MAX_LEN
// -----------------------------------------------------------------------------
package seqdet_pkg;

  localparam logic SEQDET_NOL = 1'b0;
  localparam logic SEQDET_OVL = 1'b1;

  localparam int SEQDET_MAX_LEN = 8;
  localparam int SEQDET_LEN_W   = $clog2(SEQDET_MAX_LEN + 1);

  localparam logic [SEQDET_MAX_LEN-1:0] SEQDET_DEF_PATTERN = 8'b0000_1001;
  localparam int                        SEQDET_DEF_LEN     = 4;
  localparam logic                      SEQDET_DEF_OVERLAP = SEQDET_NOL;

  typedef struct packed {
    logic [SEQDET_MAX_LEN-1:0] pattern;
    logic [SEQDET_LEN_W-1:0]   len;
    logic                      overlap;
  } seqdet_cfg_t;

endpackage

// File: rtl/seqdet_cmp.sv
// -----------------------------------------------------------------------------
// seqdet_cmp
// Purely combinational masked compare of the window {hist, x} against the
// low 'len' bits of 'pattern'. Bits at or above 'len' are ignored, so a
// len of zero compares equal; the caller is expected to gate that case.
// Ports:
//   hist    in  MAX_LEN-1  history, newest bit at LSB
//   x       in  1          bit currently presented (becomes window LSB)
//   pattern in  MAX_LEN    LSB-aligned pattern, bit [len-1] received first
//   len     in  LEN_W      effective length (already clamped)
//   eq      out 1          masked window equals pattern
// -----------------------------------------------------------------------------
module seqdet_cmp
  import seqdet_pkg::*;
#(
  parameter int MAX_LEN = SEQDET_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-2:0] hist,
  input  logic               x,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               eq
);

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;

  assign window = {hist, x};

  // Thermometer mask selecting the low 'len' bit positions
  always_comb begin
    mask = {MAX_LEN{1'b0}};
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) begin
        mask[i] = 1'b1;
      end else begin
        mask[i] = 1'b0;
      end
    end
  end

  assign eq = (((window ^ pattern) & mask) == {MAX_LEN{1'b0}});

endmodule

// File: rtl/seq_detector_prog.sv
// -----------------------------------------------------------------------------
// seq_detector_prog
// Runtime-programmable Mealy serial-pattern detector with valid qualification,
// overlapping / non-overlapping modes and a registered copy of the match.
// Optional feature macro: SEQDET_MATCH_CNT_EN adds a saturating match counter
// and the match_cnt port.
// Ports:
//   clk          in  1        rising-edge clock
//   rst          in  1        synchronous reset, active-high
//   in_valid     in  1        x carries a stream bit this cycle
//   x            in  1        serial input bit
//   cfg_load     in  1        latch cfg_* and clear history (x ignored)
//   cfg_pattern  in  MAX_LEN  pattern, LSB-aligned
//   cfg_len      in  LEN_W    pattern length (0 disables, >MAX_LEN clamps)
//   cfg_overlap  in  1        1 = overlapping detection
//   y            out 1        combinational Mealy match
//   y_q          out 1        y delayed by one clock
//   match_cnt    out CNT_W    saturating match count (macro only)
// The detector's only state is the (hist, fill) pair plus the config.
// -----------------------------------------------------------------------------
module seq_detector_prog
  import seqdet_pkg::*;
#(
  parameter int                 MAX_LEN         = SEQDET_MAX_LEN,
  parameter int                 LEN_W           = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(SEQDET_DEF_PATTERN),
  parameter int                 DEFAULT_LEN     = SEQDET_DEF_LEN,
  parameter logic               DEFAULT_OVERLAP = SEQDET_DEF_OVERLAP,
  parameter int                 CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               y,
  output logic               y_q
`ifdef SEQDET_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  localparam int               HIST_W   = MAX_LEN - 1;
  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
  localparam logic [LEN_W-1:0] DEF_LEN  = (DEFAULT_LEN > MAX_LEN) ?
                                          LEN_W'(MAX_LEN) : LEN_W'(DEFAULT_LEN);

  logic [MAX_LEN-1:0] pattern_r;
  logic [LEN_W-1:0]   len_r;
  logic               overlap_r;
  logic [HIST_W-1:0]  hist_r;
  logic [LEN_W-1:0]   fill_r;
  logic               y_q_r;

  logic [LEN_W-1:0]   len_clamped_s;
  logic               len_ok_s;
  logic               cmp_eq_s;
  logic               y_s;

  // Clamp the requested length so stored L never exceeds MAX_LEN
  always_comb begin
    len_clamped_s = cfg_len;
    if (int'(cfg_len) > MAX_LEN) begin
      len_clamped_s = LEN_W'(MAX_LEN);
    end else begin
      len_clamped_s = cfg_len;
    end
  end

  // Enough history held for a full-length window; L = 0 never matches
  always_comb begin
    len_ok_s = 1'b0;
    if (len_r == {LEN_W{1'b0}}) begin
      len_ok_s = 1'b0;
    end else begin
      len_ok_s = (fill_r >= (len_r - LEN_W'(1)));
    end
  end

  seqdet_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist    (hist_r),
    .x       (x),
    .pattern (pattern_r),
    .len     (len_r),
    .eq      (cmp_eq_s)
  );

  // Reset and cfg_load both force the Mealy output low
  assign y_s = in_valid & ~cfg_load & ~rst & len_ok_s & cmp_eq_s;
  assign y   = y_s;
  assign y_q = y_q_r;

  // Config, history/fill and registered-match state
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_r <= DEFAULT_PATTERN;
      len_r     <= DEF_LEN;
      overlap_r <= DEFAULT_OVERLAP;
      hist_r    <= {HIST_W{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
      y_q_r     <= 1'b0;
    end else begin
      y_q_r <= y_s;
      if (cfg_load) begin
        pattern_r <= cfg_pattern;
        len_r     <= len_clamped_s;
        overlap_r <= cfg_overlap;
        hist_r    <= {HIST_W{1'b0}};
        fill_r    <= {LEN_W{1'b0}};
      end else if (in_valid) begin
        if (y_s && (overlap_r == SEQDET_NOL)) begin
          // Matching bit is consumed: restart the search from scratch
          hist_r <= {HIST_W{1'b0}};
          fill_r <= {LEN_W{1'b0}};
        end else begin
          hist_r <= HIST_W'({hist_r, x});
          if (fill_r != FILL_MAX) begin
            fill_r <= fill_r + LEN_W'(1);
          end else begin
            fill_r <= fill_r;
          end
        end
      end else begin
        hist_r <= hist_r;
        fill_r <= fill_r;
      end
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_r;

  assign match_cnt = cnt_r;

  // Saturating match counter, cleared on reset and reconfiguration
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cfg_load) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (y_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  // Counter width only matters when the counter is built
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_prog
// Table-driven directed bench for seq_detector_prog. Each record drives one
// clock of inputs; y is compared against a hand-computed value and y_q
// against the previous record's y. Build with SEQDET_MATCH_CNT_EN defined to
// include the match counter.
// -----------------------------------------------------------------------------
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       x;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       y;
  logic       y_q;
`ifdef SEQDET_MATCH_CNT_EN
  logic [7:0] match_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detector_prog dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .x           (x),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .y           (y),
    .y_q         (y_q)
`ifdef SEQDET_MATCH_CNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  typedef struct {
    logic       r;
    logic       ld;
    logic [7:0] p;
    logic [3:0] l;
    logic       o;
    logic       v;
    logic       xb;
    logic       ey;
    logic       eyq;
    int         ecnt;  // -1: counter not checked on this record
    string      tag;
  } vec_t;

  vec_t  vecs[$];
  logic  last_ey = 1'b0;
  string cur_tag = "init";

  function automatic void add(logic r, logic ld, logic [7:0] p, logic [3:0] l,
                              logic o, logic v, logic xb, logic ey, int ecnt);
    vec_t t;
    t.r = r; t.ld = ld; t.p = p; t.l = l; t.o = o;
    t.v = v; t.xb = xb; t.ey = ey; t.eyq = last_ey;
    t.ecnt = ecnt; t.tag = cur_tag;
    last_ey = ey;
    vecs.push_back(t);
  endfunction

  function automatic void load(logic [7:0] p, logic [3:0] l, logic o);
    add(1'b0, 1'b1, p, l, o, 1'b0, 1'b0, 1'b0, -1);
  endfunction

  function automatic void bitv(logic v, logic xb, logic ey, int ecnt);
    add(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, v, xb, ey, ecnt);
  endfunction

  // One valid bit per clock; chars of 'ys' give expected y per bit
  function automatic void stream(string bits, string ys, int cnt_last);
    for (int i = 0; i < bits.len(); i++) begin
      bitv(1'b1, bits[i] == 8'h31, ys[i] == 8'h31,
           (i == bits.len() - 1) ? cnt_last : -1);
    end
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(logic r, logic ld, logic [7:0] p, logic [3:0] l,
                       logic o, logic v, logic xb);
    @(posedge clk);
    #1;
    rst = r; cfg_load = ld; cfg_pattern = p; cfg_len = l;
    cfg_overlap = o; in_valid = v; x = xb;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = 1'b0; cfg_load = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 4'h0; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);

    // ---------------- vector table ----------------
    cur_tag = "reset";
    add(1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    add(1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    cur_tag = "dflt_nol";
    stream("100100100100111011", "000100000100000000", 2);

    cur_tag = "ovl";
    load(8'b0000_1001, 4'd4, 1'b1);
    stream("100100100100111011", "000100100100100000", 4);

    cur_tag = "gaps";
    load(8'b0000_1001, 4'd4, 1'b0);
    bitv(1'b1, 1'b1, 1'b0, -1);
    repeat (3) bitv(1'b0, 1'b1, 1'b0, -1);
    bitv(1'b1, 1'b0, 1'b0, -1);
    repeat (3) bitv(1'b0, 1'b1, 1'b0, -1);
    bitv(1'b1, 1'b0, 1'b0, -1);
    repeat (3) bitv(1'b0, 1'b1, 1'b0, -1);
    bitv(1'b1, 1'b1, 1'b1, -1);
    repeat (3) bitv(1'b0, 1'b1, 1'b0, -1);

    cur_tag = "reconfig";
    stream("101100", "000000", -1);
    // x = 1 would complete the old 1001 pattern; load must suppress it
    add(1'b0, 1'b1, 8'b1011_0011, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    stream("1110110011", "0000000001", -1);

    cur_tag = "len1";
    load(8'b0000_0001, 4'd1, 1'b0);
    stream("10110", "10110", -1);
    bitv(1'b0, 1'b1, 1'b0, -1);
    load(8'b0000_0001, 4'd1, 1'b1);
    stream("1101", "1101", -1);

    cur_tag = "len0";
    load(8'b0000_0000, 4'd0, 1'b0);
    stream("0000000010", "0000000000", -1);

    cur_tag = "len15";
    load(8'b1011_0011, 4'd15, 1'b1);
    stream("101100111", "000000010", -1);

    cur_tag = "rst_mid";
    load(8'b0000_1001, 4'd4, 1'b1);
    stream("100", "000", -1);
    add(1'b1, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
    bitv(1'b1, 1'b1, 1'b0, 0);
    stream("1001001", "0001000", 1);

    // ---------------- apply table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].r, vecs[i].ld, vecs[i].p, vecs[i].l,
            vecs[i].o, vecs[i].v, vecs[i].xb);
      check($sformatf("%s[%0d].y", vecs[i].tag, i), 32'(y), 32'(vecs[i].ey));
      check($sformatf("%s[%0d].y_q", vecs[i].tag, i), 32'(y_q), 32'(vecs[i].eyq));
`ifdef SEQDET_MATCH_CNT_EN
      if (vecs[i].ecnt >= 0) begin
        check($sformatf("%s[%0d].cnt", vecs[i].tag, i), 32'(match_cnt),
              vecs[i].ecnt);
      end
`endif
    end

    // ---------------- counter saturation: 300 matches at L=1 ----------------
    drive(1'b0, 1'b1, 8'b0000_0001, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 300; k++) begin
      drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
      if (k == 0 || k == 299) begin
        check($sformatf("sat[%0d].y", k), 32'(y), 32'd1);
      end
    end
    drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
    check("sat_end.y", 32'(y), 32'd0);
    check("sat_end.y_q", 32'(y_q), 32'd1);
`ifdef SEQDET_MATCH_CNT_EN
    check("sat_end.cnt", 32'(match_cnt), 32'd255);
`endif
    // Load while a match would otherwise fire: y low, counter cleared
    drive(1'b0, 1'b1, 8'b0000_0001, 4'd1, 1'b1, 1'b1, 1'b1);
    check("ld_sup.y", 32'(y), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    check("ld_sup.y_q", 32'(y_q), 32'd0);
`ifdef SEQDET_MATCH_CNT_EN
    check("ld_sup.cnt", 32'(match_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
